// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths and helpers for the data-memory responder.
// Word/address widths come from the RISC-V core defines. The fallbacks below
// apply only when riscv_defines.v has not already been read.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

package dmem_responder_pkg;
  localparam int unsigned DMEM_WORD_W = `RISCV_WORD_WIDTH;
  localparam int unsigned DMEM_ADDR_W = `RISCV_ADDR_WIDTH;
  localparam int unsigned DMEM_BE_W   = DMEM_WORD_W / 8;
  // Wide enough for LATENCY-1 with LATENCY up to 15
  localparam int unsigned DMEM_CNT_W  = 4;

  // Word-index width; a single-word memory still needs one index bit.
  function automatic int unsigned dmem_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word memory with per-byte write enables and a
// registered (synchronous) read. Contents are never reset.
// Ports:
//   clk      - rising-edge clock
//   i_idx    - word index (read and write share it)
//   i_we     - per-byte write enables, 0 means no write
//   i_wdata  - lane-aligned write data
//   o_rdata  - word at i_idx as of the previous edge (old data on a write)
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = dmem_idx_w(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [DMEM_BE_W-1:0]   i_we,
  input  logic [DMEM_WORD_W-1:0] i_wdata,
  output logic [DMEM_WORD_W-1:0] o_rdata
);

  logic [DMEM_WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_idx];
    for (int unsigned b = 0; b < DMEM_BE_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency responder for a valid/ready data-memory port.
// A request seen in IDLE is captured, held for LATENCY cycles, then answered
// with a one-cycle ready pulse carrying read data (pre-write data for writes)
// and an error flag for word indices beyond DEPTH_WORDS.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   dmem_valid_i  - request present
//   dmem_addr_i   - byte address, bits [1:0] ignored
//   dmem_wdata_i  - lane-aligned write data
//   dmem_we_i     - per-byte write enables, 0 = read
//   dmem_ready_o  - one-cycle completion pulse
//   dmem_rdata_o  - response data, held between responses
//   err_o         - out-of-range flag, qualified by dmem_ready_o
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dmem_valid_i,
  output logic                          dmem_ready_o,
  input  logic [`RISCV_ADDR_WIDTH-1:0]  dmem_addr_i,
  input  logic [`RISCV_WORD_WIDTH-1:0]  dmem_wdata_i,
  input  logic [3:0]                    dmem_we_i,
  output logic [`RISCV_WORD_WIDTH-1:0]  dmem_rdata_o,
  output logic                          err_o
);

  localparam int unsigned IW = dmem_idx_w(DEPTH_WORDS);
  localparam int unsigned AW = DMEM_ADDR_W;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]             r_state;
  logic [DMEM_CNT_W-1:0]  r_wait_cnt;
  logic [AW-1:2]          r_addr;
  logic [3:0]             r_we;
  logic [DMEM_WORD_W-1:0] r_wdata;
  logic                   r_ready;
  logic                   r_err;
  logic [DMEM_WORD_W-1:0] r_rdata;

  logic                   w_oor;
  logic [IW-1:0]          w_ram_idx;
  logic [3:0]             w_ram_we;
  logic [DMEM_WORD_W-1:0] w_ram_q;
  logic                   w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^dmem_addr_i[1:0];

  // Full-width compare so addresses past the array never alias onto it.
  assign w_oor = ({2'b00, r_addr} >= DEPTH_A);

  // The RAM reads at the incoming address while idle, so its registered
  // output already holds the requested word by the time RESP is reached,
  // even with LATENCY=1.
  assign w_ram_idx = (r_state == S_IDLE) ? dmem_addr_i[2 +: IW] : r_addr[2 +: IW];
  assign w_ram_we  = (r_state == S_RESP && !w_oor) ? r_we : '0;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_idx   (w_ram_idx),
    .i_we    (w_ram_we),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // Outputs are registered on the edge that leaves RESP, the same edge that
  // commits the write, so the pulse appears exactly LATENCY cycles after
  // acceptance. The counter therefore releases on reaching zero rather than
  // one cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_we       <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dmem_valid_i) begin
            r_addr  <= dmem_addr_i[AW-1:2];
            r_we    <= dmem_we_i;
            r_wdata <= dmem_wdata_i;
            if (LATENCY <= 1) begin
              r_wait_cnt <= '0;
              r_state    <= S_RESP;
            end else begin
              r_wait_cnt <= DMEM_CNT_W'(LATENCY - 1);
              r_state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
          if (r_wait_cnt == DMEM_CNT_W'(1)) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_err   <= w_oor;
          r_rdata <= w_oor ? '0 : w_ram_q;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_ready_o = r_ready;
  assign err_o        = r_err;
  assign dmem_rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int NI = 3;   // 0: LATENCY=1, 1: LATENCY=3, 2: LATENCY=4

  logic        clk = 1'b0;
  logic        rst_n [NI];
  logic        valid [NI];
  logic        ready [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  we    [NI];
  logic [31:0] rdata [NI];
  logic        err   [NI];

  int errors = 0;
  int checks = 0;

  // Reference memory: one independent array per instance.
  logic [31:0] mdl [NI][1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n[0]), .dmem_valid_i(valid[0]), .dmem_ready_o(ready[0]),
    .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_we_i(we[0]),
    .dmem_rdata_o(rdata[0]), .err_o(err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n[1]), .dmem_valid_i(valid[1]), .dmem_ready_o(ready[1]),
    .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_we_i(we[1]),
    .dmem_rdata_o(rdata[1]), .err_o(err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n[2]), .dmem_valid_i(valid[2]), .dmem_ready_o(ready[2]),
    .dmem_addr_i(addr[2]), .dmem_wdata_i(wdata[2]), .dmem_we_i(we[2]),
    .dmem_rdata_o(rdata[2]), .err_o(err[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response from the memory rules: out-of-range -> err, data 0,
  // no write; otherwise old word returned and enabled lanes replaced.
  task automatic model_op(input int i, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, output logic [31:0] exp_d,
                          output logic exp_e);
    int idx;
    exp_e = (a[31:2] >= 30'd1024);
    idx   = int'(a[11:2]);
    exp_d = exp_e ? 32'h0 : mdl[i][idx];
    if (!exp_e)
      for (int b = 0; b < 4; b++)
        if (w[b]) mdl[i][idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One transaction; ready must appear exactly LATENCY cycles after the
  // accepting edge. hold=0 drops valid right after acceptance.
  task automatic txn(input int i, input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, input bit hold, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    lat = lat_of(i);
    model_op(i, a, w, d, exp_d, exp_e);
    valid[i] = 1'b1; addr[i] = a; we[i] = w; wdata[i] = d;
    @(posedge clk); #1;
    if (!hold) valid[i] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s ready@%0d", tag, k), {31'd0, ready[i]}, {31'd0, (k == lat)});
    end
    chk({tag, " err"}, {31'd0, err[i]}, {31'd0, exp_e});
    chk({tag, " rdata"}, rdata[i], exp_d);
    valid[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] ra;
    logic [31:0] b2b_addr [4];

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; valid[i] = 1'b0; addr[i] = '0; wdata[i] = '0; we[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst ready%0d", i), {31'd0, ready[i]}, 32'd0);
      chk($sformatf("rst err%0d", i),   {31'd0, err[i]},   32'd0);
      chk($sformatf("rst rdata%0d", i), rdata[i],          32'd0);
    end
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, LATENCY=3
    txn(1, 32'h10, 4'hF, 32'hDEADBEEF, 1, "l3 wr10");
    txn(1, 32'h10, 4'h0, 32'h0,        1, "l3 rd10");
    chk("l3 rd10 value", rdata[1], 32'hDEADBEEF);

    // Byte lanes
    txn(1, 32'h20, 4'hF,    32'h11223344, 1, "l3 wr20");
    txn(1, 32'h20, 4'b0100, 32'h00AA0000, 1, "l3 be0100");
    txn(1, 32'h20, 4'h0,    32'h0,        1, "l3 rd20a");
    chk("l3 rd20a value", rdata[1], 32'h11AA3344);
    txn(1, 32'h22, 4'b0011, 32'hFFFF5566, 1, "l3 be0011");
    txn(1, 32'h20, 4'h0,    32'h0,        1, "l3 rd20b");
    chk("l3 rd20b value", rdata[1], 32'h11AA5566);
    txn(1, 32'h20, 4'b0101, 32'hA1B2C3D4, 1, "l3 be0101");
    txn(1, 32'h20, 4'h0,    32'h0,        1, "l3 rd20c");

    // Out of range: index 1024 aliases word 0 if the range check is missing
    txn(1, 32'h0,    4'hF, 32'hCAFEF00D, 1, "l3 wr0");
    txn(1, 32'h1000, 4'hF, 32'h99999999, 1, "l3 oor wr");
    txn(1, 32'hFFFFFFFC, 4'h0, 32'h0,    1, "l3 oor rd");
    txn(1, 32'h0,    4'h0, 32'h0,        1, "l3 rd0");
    chk("l3 rd0 value", rdata[1], 32'hCAFEF00D);
    txn(1, 32'hFFC,  4'hF, 32'h0BADC0DE, 1, "l3 last word");
    txn(1, 32'hFFC,  4'h0, 32'h0,        1, "l3 rd last");

    // Back-to-back with valid held, LATENCY=1
    for (int n = 0; n < 4; n++) begin
      b2b_addr[n] = 32'h200 + 32'(n * 4);
      txn(0, b2b_addr[n], 4'hF, 32'h1000_0000 * 32'(n + 1) + 32'h55, 1, "l1 init");
    end
    valid[0] = 1'b1; we[0] = 4'h0; wdata[0] = '0; addr[0] = b2b_addr[0];
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      chk($sformatf("l1 b2b ready e%0d", e), {31'd0, ready[0]}, {31'd0, (e % 2 == 1)});
      if (e % 2 == 1) begin
        model_op(0, b2b_addr[e/2], 4'h0, 32'h0, exp_d, exp_e);
        chk($sformatf("l1 b2b rdata e%0d", e), rdata[0], exp_d);
        chk($sformatf("l1 b2b err e%0d", e), {31'd0, err[0]}, 32'd0);
      end
      if (e % 2 == 0 && e < 6) addr[0] = b2b_addr[e/2 + 1];
      if (e == 6) valid[0] = 1'b0;
    end

    // Valid drop, LATENCY=4
    txn(2, 32'h40, 4'hF, 32'h5, 0, "l4 drop wr");
    txn(2, 32'h40, 4'h0, 32'h0, 1, "l4 drop rd");
    chk("l4 drop value", rdata[2], 32'h5);

    // Reset mid-WAIT aborts the write
    txn(2, 32'h44, 4'hF, 32'h12, 1, "l4 pre wr");
    valid[2] = 1'b1; addr[2] = 32'h44; we[2] = 4'hF; wdata[2] = 32'h77;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    chk("l4 async rst ready", {31'd0, ready[2]}, 32'd0);
    chk("l4 async rst rdata", rdata[2], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("l4 post rst ready%0d", k), {31'd0, ready[2]}, 32'd0);
    end
    txn(2, 32'h44, 4'h0, 32'h0, 1, "l4 rd44");
    chk("l4 rd44 value", rdata[2], 32'h12);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 16; n++)
        txn(i, 32'h100 + 32'(n * 4), 4'hF, $urandom, 1, $sformatf("rnd init%0d", i));
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 7) == 0) ra = 32'h1000 | $urandom;
        else ra = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        txn(i, ra, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) == 1,
            $sformatf("rnd i%0d n%0d", i, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
